bird_physics: RTL

- Vertical motion engine for the bird sprite: integrates gravity and flap impulses once per video frame.
- Consumes the 3-bit game state and the conditioned single-cycle jump pulse.
- Produces bird position and velocity for the renderer and collision logic.
- Its hit_bound output is OR-ed with the pipe-overlap signal to form is_collide for the game-state FSM.

---
 rtl/game_pkg.sv | 19 +
 rtl/vel_step.sv | 36 +++
 rtl/bird_physics.sv | 136 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants and state codes.
// Used by the game-state FSM, the bird physics engine and the renderer.
//   - STATE_W / game_state_t : 3-bit game state encoding (WAIT, PLAY, DEAD)
//   - SCREEN_H, Y_W, VY_W    : screen geometry and pixel/velocity widths
package game_pkg;

    localparam int STATE_W  = 3;
    localparam int SCREEN_H = 480;
    localparam int Y_W      = 10;
    localparam int VY_W     = 6;

    // Codes 3..7 are not named; consumers treat them as WAIT.
    typedef enum logic [STATE_W-1:0] {
        ST_WAIT = 3'd0,
        ST_PLAY = 3'd1,
        ST_DEAD = 3'd2
    } game_state_t;

endpackage

// File: rtl/vel_step.sv
// Combinational per-frame velocity update for the bird.
// Ports:
//   vy     in  current signed velocity (positive = downward)
//   flap   in  load the flap impulse instead of applying gravity
//   vy_new out next signed velocity, saturated at VMAX
module vel_step #(
    parameter int VY_W     = 6,
    parameter int GRAVITY  = 1,
    parameter int JUMP_VEL = -10,
    parameter int VMAX     = 12
) (
    input  logic signed [VY_W-1:0] vy,
    input  logic                   flap,
    output logic signed [VY_W-1:0] vy_new
);

    localparam logic signed [VY_W:0]   VMAX_W = (VY_W+1)'(VMAX);
    localparam logic signed [VY_W:0]   GRAV_W = (VY_W+1)'(GRAVITY);
    localparam logic signed [VY_W-1:0] VMAX_N = VY_W'(VMAX);
    localparam logic signed [VY_W-1:0] JUMP_N = VY_W'(JUMP_VEL);

    // One extra bit so vy+GRAVITY cannot wrap before the clamp.
    logic signed [VY_W:0] inc;

    always_comb begin
        inc = $signed({vy[VY_W-1], vy}) + GRAV_W;
        if (flap) begin
            vy_new = JUMP_N;
        end else if (inc > VMAX_W) begin
            vy_new = VMAX_N;
        end else begin
            vy_new = inc[VY_W-1:0];
        end
    end

endmodule

// File: rtl/bird_physics.sv
// Vertical motion engine for the bird sprite.
// Integrates gravity and flap impulses once per video frame and clamps the
// bird between the ceiling (row 0) and the floor (SCREEN_H-BIRD_H).
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   frame_tick in  one-cycle pulse per video frame
//   jump       in  one-cycle debounced flap pulse
//   game_state in  WAIT=0, PLAY=1, DEAD=2 (3..7 treated as WAIT)
//   bird_y     out top row of sprite, unsigned
//   bird_vy    out signed velocity, positive = downward
//   hit_bound  out floor reached; sticky until state returns to WAIT
module bird_physics
    import game_pkg::*;
#(
    parameter int Y_W      = game_pkg::Y_W,
    parameter int VY_W     = game_pkg::VY_W,
    parameter int SCREEN_H = game_pkg::SCREEN_H,
    parameter int BIRD_H   = 24,
    parameter int Y_START  = 228,
    parameter int GRAVITY  = 1,
    parameter int JUMP_VEL = -10,
    parameter int VMAX     = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   jump,
    input  logic [STATE_W-1:0]     game_state,
    output logic [Y_W-1:0]         bird_y,
    output logic signed [VY_W-1:0] bird_vy,
    output logic                   hit_bound
);

    localparam int YS_W = Y_W + 2;
    localparam logic [Y_W-1:0]         Y_START_V = Y_W'(Y_START);
    localparam logic [Y_W-1:0]         FLOOR_V   = Y_W'(SCREEN_H - BIRD_H);
    localparam logic signed [YS_W-1:0] FLOOR_S   = YS_W'(SCREEN_H - BIRD_H);

    logic [Y_W-1:0]         y_reg, y_next;
    logic signed [VY_W-1:0] vy_reg, vy_next;
    logic                   hit_reg, hit_next;
    logic                   pend_reg, pend_next;

    game_state_t            st;
    logic                   flap;
    logic signed [VY_W-1:0] vy_new;
    logic signed [YS_W-1:0] y_sum;

    // Unknown codes collapse to WAIT.
    always_comb begin
        case (game_state)
            3'd1:    st = ST_PLAY;
            3'd2:    st = ST_DEAD;
            default: st = ST_WAIT;
        endcase
    end

    // A flap only steers the bird while playing; in DEAD it just falls.
    assign flap = (st == ST_PLAY) && (pend_reg || jump);

    vel_step #(
        .VY_W     (VY_W),
        .GRAVITY  (GRAVITY),
        .JUMP_VEL (JUMP_VEL),
        .VMAX     (VMAX)
    ) u_vel_step (
        .vy     (vy_reg),
        .flap   (flap),
        .vy_new (vy_new)
    );

    // Two guard bits: one for the sign, one so y+vy cannot wrap.
    assign y_sum = $signed({2'b00, y_reg}) +
                   $signed({{(YS_W-VY_W){vy_new[VY_W-1]}}, vy_new});

    always_comb begin
        y_next    = y_reg;
        vy_next   = vy_reg;
        hit_next  = hit_reg;
        pend_next = pend_reg;

        case (st)
            ST_PLAY, ST_DEAD: begin
                if (st == ST_DEAD) begin
                    pend_next = 1'b0;
                end else if (frame_tick) begin
                    pend_next = 1'b0;          // consumed by this frame
                end else begin
                    pend_next = pend_reg | jump;
                end

                if (frame_tick) begin
                    if (y_sum < 0) begin
                        // Ceiling stops the bird but is not fatal.
                        y_next  = '0;
                        vy_next = '0;
                    end else if (y_sum >= FLOOR_S) begin
                        y_next   = FLOOR_V;
                        vy_next  = '0;
                        hit_next = 1'b1;
                    end else begin
                        y_next  = y_sum[Y_W-1:0];
                        vy_next = vy_new;
                    end
                end
            end
            default: begin
                // WAIT parks the bird; a jump here arms the first PLAY frame.
                y_next    = Y_START_V;
                vy_next   = '0;
                hit_next  = 1'b0;
                pend_next = pend_reg | jump;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg    <= Y_START_V;
            vy_reg   <= '0;
            hit_reg  <= 1'b0;
            pend_reg <= 1'b0;
        end else begin
            y_reg    <= y_next;
            vy_reg   <= vy_next;
            hit_reg  <= hit_next;
            pend_reg <= pend_next;
        end
    end

    assign bird_y    = y_reg;
    assign bird_vy   = vy_reg;
    assign hit_bound = hit_reg;

endmodule
